lsu_unit: RTL

Load/store unit for the RV32 core. Executes the memory instruction codes (27–34: LB, LH, LW, LBU, LHU, SB, SH, SW) that the ALU does not handle, and runs a request/acknowledge data-memory transaction for each. It sits alongside the ALU in the execute stage, using the same decoded instruction code, IR and operand inputs. Its load result and load-enable feed the register-file writeback mux.

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_align.sv | 56 +++++
 rtl/lsu_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared opcode constants, FSM encoding and small helpers for the load/store unit.
package lsu_pkg;

  localparam logic [31:0] OP_LB  = 32'd27;
  localparam logic [31:0] OP_LH  = 32'd28;
  localparam logic [31:0] OP_LW  = 32'd29;
  localparam logic [31:0] OP_LBU = 32'd30;
  localparam logic [31:0] OP_LHU = 32'd31;
  localparam logic [31:0] OP_SB  = 32'd32;
  localparam logic [31:0] OP_SH  = 32'd33;
  localparam logic [31:0] OP_SW  = 32'd34;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  // The wait counter only ever holds 0 .. timeout-1.
  function automatic int cnt_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

  function automatic logic is_load(input logic [31:0] op);
    return (op >= OP_LB) && (op <= OP_LHU);
  endfunction

  function automatic logic is_store(input logic [31:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  function automatic logic is_mem(input logic [31:0] op);
    return (op >= OP_LB) && (op <= OP_SW);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte-lane replication / byte enables and
// load byte/halfword extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] st_op,
  input  logic [1:0]  st_ea,
  input  logic [31:0] st_data,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  input  logic [31:0] ld_op,
  input  logic [1:0]  ld_ea,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    st_wdata = st_data;
    st_be    = 4'b1111;
    case (st_op)
      OP_SB: begin
        st_wdata = {4{st_data[7:0]}};
        st_be    = 4'b0001 << st_ea;
      end
      OP_SH: begin
        st_wdata = {2{st_data[15:0]}};
        st_be    = st_ea[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_sel = ld_rdata[7:0];
    case (ld_ea)
      2'd1:    byte_sel = ld_rdata[15:8];
      2'd2:    byte_sel = ld_rdata[23:16];
      2'd3:    byte_sel = ld_rdata[31:24];
      default: byte_sel = ld_rdata[7:0];
    endcase
    // Halfword lane follows EA[1] only, so an odd halfword address reads its aligned half.
    half_sel = ld_ea[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    ld_data  = ld_rdata;
    case (ld_op)
      OP_LB:   ld_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  ld_data = {24'd0, byte_sel};
      OP_LH:   ld_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  ld_data = {16'd0, half_sel};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_unit.sv
// Load/store unit: one request/acknowledge data-memory access per accepted command.
// Optional misaligned-access trap is enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [31:0] i_instruction,
  input  logic [31:0] i_IR,
  input  logic [31:0] i_A,
  input  logic [31:0] i_B,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_load_regfile,
  output logic [31:0] o_loadout,
  output logic        o_fault,
  output logic        o_misaligned,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  lsu_state_e state_q, state_d;

  logic [31:0] op_q, ea_q, wdata_q, loadout_q;
  logic [3:0]  be_q;
  logic        we_q, fault_q;
  logic [CW-1:0] cnt_q;

  logic [31:0] imm_load, imm_store, ea_now, st_wdata, ld_data;
  logic [3:0]  st_be;
  logic        accept, ack_req, timed_out, mis_now, mis_q;
  logic        unused_ir;

  assign unused_ir = ^{i_IR[19:12], i_IR[6:0]};

  assign imm_load  = {{20{i_IR[31]}}, i_IR[31:20]};
  assign imm_store = {{20{i_IR[31]}}, i_IR[31:25], i_IR[11:7]};
  assign ea_now    = i_A + (is_store(i_instruction) ? imm_store : imm_load);

  // Bus handshake: o_mem_req rises the cycle after acceptance and stays high with
  // addr/we/be/wdata frozen until the first cycle i_mem_ack is sampled high (which
  // also carries i_mem_rdata) or the wait budget runs out; acks outside REQ are ignored.
  assign accept    = i_start && (state_q != ST_REQ) && is_mem(i_instruction);
  assign ack_req   = (state_q == ST_REQ) && i_mem_ack;
  assign timed_out = (state_q == ST_REQ) && !i_mem_ack && (cnt_q == CNT_LAST);

`ifdef LSU_MISALIGN_TRAP_EN
  logic half_op, word_op;
  assign half_op = (i_instruction == OP_LH) || (i_instruction == OP_LHU) || (i_instruction == OP_SH);
  assign word_op = (i_instruction == OP_LW) || (i_instruction == OP_SW);
  assign mis_now = (half_op && ea_now[0]) || (word_op && (ea_now[1:0] != 2'b00));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mis_q <= 1'b0;
    end else if (accept) begin
      mis_q <= mis_now;
    end
  end

  assign o_misaligned = (state_q == ST_RESP) && mis_q;
`else
  assign mis_now      = 1'b0;
  assign mis_q        = 1'b0;
  assign o_misaligned = 1'b0;
`endif

  lsu_align u_align (
    .st_op    (i_instruction),
    .st_ea    (ea_now[1:0]),
    .st_data  (i_B),
    .st_wdata (st_wdata),
    .st_be    (st_be),
    .ld_op    (op_q),
    .ld_ea    (ea_q[1:0]),
    .ld_rdata (i_mem_rdata),
    .ld_data  (ld_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      ea_q      <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      fault_q   <= 1'b0;
      loadout_q <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= timed_out;
      if (accept) begin
        op_q    <= i_instruction;
        ea_q    <= ea_now;
        wdata_q <= st_wdata;
        be_q    <= st_be;
        we_q    <= is_store(i_instruction);
        cnt_q   <= '0;
      end else if ((state_q == ST_REQ) && !i_mem_ack) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (ack_req && is_load(op_q)) begin
        loadout_q <= ld_data;
      end
    end
  end

  // RESP doubles as an idle cycle so a new command can be taken alongside o_done.
  always_comb begin
    state_d        = state_q;
    o_busy         = 1'b0;
    o_mem_req      = 1'b0;
    o_done         = 1'b0;
    o_load_regfile = 1'b0;
    o_mem_we       = 1'b0;
    o_mem_addr     = '0;
    o_mem_be       = '0;
    o_mem_wdata    = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = mis_now ? ST_RESP : ST_REQ;
      end
      ST_REQ: begin
        o_busy      = 1'b1;
        o_mem_req   = 1'b1;
        o_mem_we    = we_q;
        o_mem_addr  = {ea_q[31:2], 2'b00};
        o_mem_be    = be_q;
        o_mem_wdata = wdata_q;
        if (ack_req) state_d = ST_RESP;
        else if (timed_out) state_d = ST_IDLE;
      end
      ST_RESP: begin
        o_done         = 1'b1;
        o_load_regfile = is_load(op_q) && !mis_q;
        state_d        = accept ? (mis_now ? ST_RESP : ST_REQ) : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_fault   = fault_q;
  assign o_loadout = loadout_q;

endmodule
